// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with valid/ready handshakes on both sides.
// Stage 1 captures operands and opcode. Stage 2 computes the operation and
// registers the result and NZVC flags, which drive the outputs directly.
// Optional feature: define ALU_SAT_EN to clamp add/sub results on signed overflow.
module alu_pipe #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       cntrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             negative,
  output logic             zero,
  output logic             overflow,
  output logic             carry_out
);

  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    OpPassB = 3'b000,
    OpShr   = 3'b001,
    OpAdd   = 3'b010,
    OpSub   = 3'b011,
    OpAnd   = 3'b100,
    OpOr    = 3'b101,
    OpXor   = 3'b110,
    OpShl   = 3'b111
  } aluOp_e;

  logic             s1Valid_q;
  logic [WIDTH-1:0] s1A_q;
  logic [WIDTH-1:0] s1B_q;
  aluOp_e           s1Op_q;

  logic             s2Valid_q;
  logic [WIDTH-1:0] result_q;
  logic             negative_q;
  logic             zero_q;
  logic             overflow_q;
  logic             carry_q;

  logic [WIDTH-1:0] result_d;
  logic             overflow_d;
  logic             carry_d;
  logic [WIDTH:0]   addSum;
  logic [WIDTH:0]   subSum;
  logic [SHW-1:0]   shAmt;
  logic             msbA;
  logic             msbB;
  logic             s2Ready;

  // Stage 2 can take a new op when it is empty or its current result is leaving;
  // stage 1 can take one when it is empty or it is handing its op to stage 2.
  assign s2Ready  = !s2Valid_q || out_ready;
  assign in_ready = !s1Valid_q || s2Ready;

  // Stage 1 register: capture operands on an input transfer, otherwise let a bubble in
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1Valid_q <= 1'b0;
      s1A_q     <= '0;
      s1B_q     <= '0;
      s1Op_q    <= OpPassB;
    end else if (in_ready) begin
      s1Valid_q <= in_valid;
      if (in_valid) begin
        s1A_q  <= A;
        s1B_q  <= B;
        s1Op_q <= aluOp_e'(cntrl);
      end
    end
  end

  // Stage 2 datapath: compute the op and its flags from the stage-1 registers
  always_comb begin
    shAmt      = s1B_q[SHW-1:0];
    msbA       = s1A_q[WIDTH-1];
    msbB       = s1B_q[WIDTH-1];
    addSum     = {1'b0, s1A_q} + {1'b0, s1B_q};
    subSum     = {1'b0, s1A_q} + {1'b0, ~s1B_q} + {{WIDTH{1'b0}}, 1'b1};
    result_d   = '0;
    overflow_d = 1'b0;
    carry_d    = 1'b0;
    case (s1Op_q)
      OpPassB: result_d = s1B_q;
      OpShr:   result_d = s1A_q >> shAmt;
      OpAdd: begin
        result_d   = addSum[WIDTH-1:0];
        carry_d    = addSum[WIDTH];
        overflow_d = (msbA == msbB) && (addSum[WIDTH-1] != msbA);
      end
      OpSub: begin
        result_d   = subSum[WIDTH-1:0];
        carry_d    = subSum[WIDTH];
        overflow_d = (msbA != msbB) && (subSum[WIDTH-1] != msbA);
      end
      OpAnd:   result_d = s1A_q & s1B_q;
      OpOr:    result_d = s1A_q | s1B_q;
      OpXor:   result_d = s1A_q ^ s1B_q;
      OpShl:   result_d = s1A_q << shAmt;
      default: result_d = '0;
    endcase
`ifdef ALU_SAT_EN
    // On signed overflow the true result has the sign of A, so clamp toward it
    if (overflow_d) begin
      result_d = msbA ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  // Stage 2 register: load a new result when stage 1 hands over, hold while stalled
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2Valid_q  <= 1'b0;
      result_q   <= '0;
      negative_q <= 1'b0;
      zero_q     <= 1'b0;
      overflow_q <= 1'b0;
      carry_q    <= 1'b0;
    end else if (s2Ready) begin
      s2Valid_q <= s1Valid_q;
      if (s1Valid_q) begin
        result_q   <= result_d;
        negative_q <= result_d[WIDTH-1];
        zero_q     <= (result_d == '0);
        overflow_q <= overflow_d;
        carry_q    <= carry_d;
      end
    end
  end

  assign out_valid = s2Valid_q;
  assign result    = result_q;
  assign negative  = negative_q;
  assign zero      = zero_q;
  assign overflow  = overflow_q;
  assign carry_out = carry_q;

endmodule
